// File: rtl/router_pkg.sv
// Types shared by the VC router arbitration blocks.
package router_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: lowest requester at or above ptr, else lowest overall.
module rr_pick #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned NUM_BITS   = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [NUM_BITS-1:0]   ptr,
    output logic                  any,
    output logic [NUM_BITS-1:0]   winner
);

    logic [NUM_INPUTS-1:0] masked;

    always_comb begin
        masked = '0;
        winner = '0;
        any    = |req;
        for (int i = 0; i < int'(NUM_INPUTS); i++) begin
            masked[i] = req[i] && (i >= int'(ptr));
        end
        // Downward scans leave the lowest matching index in winner.
        for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
            if (req[i]) winner = NUM_BITS'(i);
        end
        if (|masked) begin
            for (int i = int'(NUM_INPUTS) - 1; i >= 0; i--) begin
                if (masked[i]) winner = NUM_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with rotating pointer and optional grant lock held until release.
module rr_lock_arbiter
    import router_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned NUM_BITS   = $clog2(NUM_INPUTS),
    parameter bit          LOCK_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_INPUTS-1:0] req,
    input  logic                  en,
    input  logic                  gnt_release,
    output logic                  gnt_valid,
    output logic [NUM_INPUTS-1:0] gnt_onehot,
    output logic [NUM_BITS-1:0]   gnt_index,
    output logic                  locked
);

    localparam logic [NUM_BITS-1:0] LAST_IDX = NUM_BITS'(NUM_INPUTS - 1);

    arb_state_t            state, state_nxt;
    logic [NUM_BITS-1:0]   ptr, ptr_nxt;
    logic                  valid_nxt;
    logic [NUM_INPUTS-1:0] onehot_nxt;
    logic [NUM_BITS-1:0]   index_nxt;
    logic                  any;
    logic [NUM_BITS-1:0]   winner;

    rr_pick #(
        .NUM_INPUTS (NUM_INPUTS),
        .NUM_BITS   (NUM_BITS)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            ptr        <= '0;
            gnt_valid  <= 1'b0;
            gnt_onehot <= '0;
            gnt_index  <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            gnt_valid  <= valid_nxt;
            gnt_onehot <= onehot_nxt;
            gnt_index  <= index_nxt;
        end
    end

    // Release leaves a one-cycle bubble; a locked holder keeps its grant regardless of req.
    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        valid_nxt  = 1'b0;
        onehot_nxt = '0;
        index_nxt  = '0;
        unique case (state)
            ARB_LOCKED: begin
                if (gnt_release) begin
                    state_nxt = ARB_IDLE;
                end else begin
                    valid_nxt  = gnt_valid;
                    onehot_nxt = gnt_onehot;
                    index_nxt  = gnt_index;
                end
            end
            ARB_IDLE: begin
                if (en && any) begin
                    valid_nxt  = 1'b1;
                    index_nxt  = winner;
                    onehot_nxt = NUM_INPUTS'(1) << winner;
                    ptr_nxt    = (winner == LAST_IDX) ? '0 : winner + NUM_BITS'(1);
                    state_nxt  = LOCK_EN ? ARB_LOCKED : ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    assign locked = (state == ARB_LOCKED);

    grant_consistent : assert property (@(posedge clk) disable iff (reset)
        $onehot0(gnt_onehot) && (gnt_onehot == (NUM_INPUTS'(gnt_valid) << gnt_index)));

endmodule
